// File: rtl/minterm_sweep_ctrl.sv
// minterm_sweep_ctrl: drives all 16 vectors into a 4-input function block and checks OUT against EXPECTED.
// Optional MINTERM_SWEEP_EARLY_ABORT_EN stops the sweep at the first mismatch.
module minterm_sweep_ctrl #(
    parameter logic [15:0] EXPECTED = 16'hA655,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  func_in,
    input  logic        func_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam logic [3:0] SET_M1   = 4'(SETTLE - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  func_in_q, func_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ff_q, ff_d;
    logic        mis, last, run_d;

    assign mis = func_out != EXPECTED[idx_q];
`ifdef MINTERM_SWEEP_EARLY_ABORT_EN
    assign last = (idx_q == 4'd15) || mis;
`else
    assign last = idx_q == 4'd15;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_SETTLE;
                idx_d   = 4'd0;
                cnt_d   = SET_M1;
                table_d = 16'd0;
                err_d   = 5'd0;
                ff_d    = 4'd0;
                pass_d  = 1'b0;
            end
            S_SETTLE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? S_SAMPLE : S_SETTLE;
            end
            S_SAMPLE: begin
                table_d[idx_q] = func_out;
                if (mis) begin
                    err_d = err_q + 5'd1;
                    ff_d  = (err_q == 5'd0) ? idx_q : ff_q;
                end
                if (last) begin
                    state_d = S_FINISH;
                    pass_d  = err_d == 5'd0;
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = SET_M1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from next-state so they line up with the state they describe
        run_d     = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        func_in_d = run_d ? idx_d : 4'd0;
        busy_d    = run_d;
        done_d    = state_d == S_FINISH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 4'd0;
            func_in_q <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            table_q   <= 16'd0;
            err_q     <= 5'd0;
            ff_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            func_in_q <= func_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            table_q   <= table_d;
            err_q     <= err_d;
            ff_q      <= ff_d;
        end
    end

    assign func_in     = func_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign truth_table = table_q;
    assign err_count   = err_q;
    assign first_fail  = ff_q;
endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// tb_minterm_sweep_ctrl: table-driven sweeps against behavioural function models, plus
// mid-sweep START, held START restart, mid-sweep reset and SETTLE=3 sequences.
module tb_minterm_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;
    logic [1:0] mode1 = 2'd0, mode3 = 2'd0;
    logic use3 = 1'b0;
    int n_cmp = 0, n_bad = 0;

    logic [3:0]  fi1, fi3, ff1, ff3;
    logic        fo1, fo3, busy1, busy3, done1, done3, pass1, pass3;
    logic [15:0] tt1, tt3;
    logic [4:0]  ec1, ec3;

    always #5 clk = ~clk;

    // Modes: 0 correct, 1 stuck-at-0, 2 inverted at IN=5, 3 stuck-at-1
    function automatic logic fmodel(input logic [1:0] m, input logic [3:0] i);
        logic good;
        good = (i == 0) || (i == 2) || (i == 4) || (i == 6) || (i == 9) || (i == 10) || (i == 13) || (i == 15);
        case (m)
            2'd0: return good;
            2'd1: return 1'b0;
            2'd2: return good ^ (i == 4'd5);
            default: return 1'b1;
        endcase
    endfunction

    assign fo1 = fmodel(mode1, fi1);
    assign fo3 = fmodel(mode3, fi3);

    minterm_sweep_ctrl #(.EXPECTED(16'hA655), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .func_in(fi1), .func_out(fo1),
        .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1),
        .err_count(ec1), .first_fail(ff1));

    minterm_sweep_ctrl #(.EXPECTED(16'hA655), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .func_in(fi3), .func_out(fo3),
        .busy(busy3), .done(done3), .pass(pass3), .truth_table(tt3),
        .err_count(ec3), .first_fail(ff3));

    logic [3:0]  s_fi, s_ff;
    logic        s_busy, s_done, s_pass;
    logic [15:0] s_tt;
    logic [4:0]  s_ec;
    assign s_fi   = use3 ? fi3 : fi1;
    assign s_ff   = use3 ? ff3 : ff1;
    assign s_busy = use3 ? busy3 : busy1;
    assign s_done = use3 ? done3 : done1;
    assign s_pass = use3 ? pass3 : pass1;
    assign s_tt   = use3 ? tt3 : tt1;
    assign s_ec   = use3 ? ec3 : ec1;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] tbl;
        logic [4:0]  err;
        logic [3:0]  ff;
        logic        pass;
        int          done_edge;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (use3) start3 = v;
        else start1 = v;
    endtask

    // Runs one sweep from E0; edge indices k are counted from E0 (k=0), DONE in cycle k+1.
    task automatic sweep(input logic hold, input int mid, output int first, output int second,
                         output int nd, output int bc, output int fb);
        int s;
        s = use3 ? 3 : 1;
        first = -1; second = -1; nd = 0; bc = 0; fb = 0;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(hold);
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (s_done) begin
                if (nd == 0) first = k;
                else if (nd == 1) second = k;
                nd++;
                if (nd == 2) set_start(1'b0);
            end
            if (nd == 0 && s_busy) begin
                bc++;
                if (s_fi != 4'(k / (s + 1))) fb++;
            end
            if (mid > 0 && k == mid) set_start(1'b1);
            if (mid > 0 && k == mid + 2) set_start(1'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " func_in"}, 32'(s_fi), 0);
        chk({tag, " busy"}, 32'(s_busy), 0);
        chk({tag, " done"}, 32'(s_done), 0);
        chk({tag, " pass"}, 32'(s_pass), 0);
        chk({tag, " table"}, 32'(s_tt), 0);
        chk({tag, " err_count"}, 32'(s_ec), 0);
        chk({tag, " first_fail"}, 32'(s_ff), 0);
    endtask

    initial begin
        int first, second, nd, bc, fb;
        vecs[0] = '{2'd0, 16'hA655, 5'd0, 4'd0, 1'b1, 32};
`ifdef MINTERM_SWEEP_EARLY_ABORT_EN
        vecs[1] = '{2'd1, 16'h0000, 5'd1, 4'd0, 1'b0, 2};
        vecs[2] = '{2'd2, 16'h0035, 5'd1, 4'd5, 1'b0, 12};
        vecs[3] = '{2'd3, 16'h0003, 5'd1, 4'd1, 1'b0, 4};
`else
        vecs[1] = '{2'd1, 16'h0000, 5'd8, 4'd0, 1'b0, 32};
        vecs[2] = '{2'd2, 16'hA675, 5'd1, 4'd5, 1'b0, 32};
        vecs[3] = '{2'd3, 16'hFFFF, 5'd8, 4'd1, 1'b0, 32};
`endif
        #12;
        use3 = 1'b0; #1 chk_zero("reset dut1");
        use3 = 1'b1; #1 chk_zero("reset dut3");
        use3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            mode1 = vecs[v].mode;
            sweep(1'b0, 0, first, second, nd, bc, fb);
            chk($sformatf("v%0d done_edge", v), 32'(first), 32'(vecs[v].done_edge));
            chk($sformatf("v%0d done_pulses", v), 32'(nd), 1);
            chk($sformatf("v%0d busy_cycles", v), 32'(bc), 32'(vecs[v].done_edge));
            chk($sformatf("v%0d func_in_seq", v), 32'(fb), 0);
            chk($sformatf("v%0d table", v), 32'(s_tt), 32'(vecs[v].tbl));
            chk($sformatf("v%0d err_count", v), 32'(s_ec), 32'(vecs[v].err));
            chk($sformatf("v%0d first_fail", v), 32'(s_ff), 32'(vecs[v].ff));
            chk($sformatf("v%0d pass", v), 32'(s_pass), 32'(vecs[v].pass));
            chk($sformatf("v%0d busy_after", v), 32'(s_busy), 0);
        end

        mode1 = 2'd0;
        sweep(1'b0, 10, first, second, nd, bc, fb);
        chk("midstart done_edge", 32'(first), 32);
        chk("midstart done_pulses", 32'(nd), 1);
        chk("midstart pass", 32'(s_pass), 1);

        sweep(1'b1, 0, first, second, nd, bc, fb);
        chk("hold first_done", 32'(first), 32);
        chk("hold second_done", 32'(second), 66);
        chk("hold table", 32'(s_tt), 32'h0000A655);

        mode1 = 2'd3;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done1 || busy1) nd++;
        end
        chk("midreset no_activity", 32'(nd), 0);

        use3 = 1'b1;
        mode3 = 2'd0;
        sweep(1'b0, 0, first, second, nd, bc, fb);
        chk("s3 done_edge", 32'(first), 64);
        chk("s3 done_pulses", 32'(nd), 1);
        chk("s3 busy_cycles", 32'(bc), 64);
        chk("s3 func_in_seq", 32'(fb), 0);
        chk("s3 table", 32'(s_tt), 32'h0000A655);
        chk("s3 err_count", 32'(s_ec), 0);
        chk("s3 pass", 32'(s_pass), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
